accelerator_dma_master: RTL and testbench
=========================================

// Module: accelerator_dma_master
// PURPOSE
//   Avalon-MM master half of the accelerator: on a rising edge of START (driven by
//   the slave register block) copies LENGTH 32-bit words from SRC_ADDR to DST_ADDR,
//   one read then one write per word, then pulses DONE back to the slave block.
//   Sits between the slave register file and the system interconnect.
// PARAMETERS
//   AVM_AVALONMASTER_DATA_WIDTH     32  data bus width; word = 4 bytes
//   AVM_AVALONMASTER_ADDRESS_WIDTH  32  byte address width
//   LENGTH_WIDTH                    16  width of word-count input
// PORTS
//   CSI_CLOCK_CLK                   in   1    single clock, all logic posedge
//   CSI_CLOCK_RESET_N               in   1    reset, asynchronous, active-low
//   START                           in   1    level from slave reg; rising edge starts a job
//   SRC_ADDR                        in   AW   source byte address (word aligned)
//   DST_ADDR                        in   AW   destination byte address (word aligned)
//   LENGTH                          in   LW   number of words to copy
//   DONE                            out  1    1-cycle pulse at job completion
//   BUSY                            out  1    high from accepted START until DONE cycle
//   AVM_AVALONMASTER_ADDRESS        out  AW   byte address
//   AVM_AVALONMASTER_READ           out  1    read request
//   AVM_AVALONMASTER_WRITE          out  1    write request
//   AVM_AVALONMASTER_WAITREQUEST    in   1    slave stall
//   AVM_AVALONMASTER_READDATA       in   DW   read data, valid when READ & ~WAITREQUEST
//   AVM_AVALONMASTER_WRITEDATA      out  DW   write data
//   CHECKSUM                        out  32   (only with ACC_CHECKSUM_EN) sum of words read
// BEHAVIOUR
//   Reset (async, RESET_N=0): state IDLE; DONE, BUSY, READ, WRITE=0; ADDRESS, WRITEDATA,
//     counters, CHECKSUM=0. Reset mid-job aborts immediately; no bus request survives.
//   START edge detect: registered START_d; start = START & ~START_d, sampled in IDLE only.
//     Edges outside IDLE ignored; START held high does not retrigger; needs 0 then 1.
//   On start: latch SRC_ADDR, DST_ADDR, LENGTH into internal regs (inputs may change after).
//   FSM: IDLE -> (start, LENGTH!=0) RD -> WR -> RD ... -> FIN -> IDLE
//        IDLE -> (start, LENGTH==0) FIN -> IDLE  (no bus traffic, DONE still pulses)
//   RD: READ=1, ADDRESS=src_ptr; hold all outputs stable while WAITREQUEST=1.
//       Cycle with WAITREQUEST=0: capture READDATA into WRITEDATA reg, src_ptr+=4, -> WR.
//   WR: WRITE=1, ADDRESS=dst_ptr, WRITEDATA held; stable while WAITREQUEST=1.
//       Cycle with WAITREQUEST=0: dst_ptr+=4, remaining-=1; remaining==0 -> FIN else RD.
//   FIN: DONE=1 for exactly one cycle, BUSY deasserts same edge as DONE falls -> IDLE.
//   READ and WRITE never asserted together; both registered outputs.
//   Min latency per word with WAITREQUEST=0: 2 cycles; job = 2*LENGTH + 2 cycles start->DONE.
//   Pointer arithmetic modulo 2^AW (wraps silently past all-ones). Unaligned addresses:
//     low two bits passed through unmodified; not checked.
//   LENGTH = 2^LW-1 supported; remaining counter is LW bits.
// CONFIGURATION
//   `define ACC_CHECKSUM_EN: CHECKSUM port present; cleared to 0 on accepted start,
//     += READDATA (mod 2^32) on each accepted read; holds value after DONE until next start.
//   Without macro: CHECKSUM port and accumulator absent; all other behaviour identical.
// TESTING
//   1 LENGTH=4, SRC=0x1000, DST=0x2000, mem[0x1000..]=1,2,3,4, no stall -> dst=1,2,3,4,
//     DONE pulse at cycle 10 after START edge, CHECKSUM=10 (with macro).
//   2 Same job, WAITREQUEST high 3 cycles on every request -> identical memory result,
//     ADDRESS/READ/WRITE/WRITEDATA stable during every stall, no duplicate transfers.
//   3 LENGTH=0 -> no READ/WRITE ever asserted, DONE pulses 2 cycles after START edge.
//   4 START held high through DONE and beyond -> exactly one job; drop to 0 then 1 -> second job.
//   5 SRC=0xFFFFFFFC, LENGTH=2 -> reads 0xFFFFFFFC then 0x00000000 (wrap).
//   6 RESET_N low while WR stalled -> READ=WRITE=BUSY=DONE=0 asynchronously, FSM IDLE;
//     subsequent START edge runs a clean job.

Source files
------------

// File: rtl/accelerator_dma_master.sv
// ---------------------------------------------------------------------------
// accelerator_dma_master
//
// Avalon-MM master half of the accelerator. A rising edge on START (seen
// while idle) latches SRC_ADDR, DST_ADDR and LENGTH. The block then copies
// LENGTH 32-bit words, one read followed by one write per word, and finally
// pulses DONE for one cycle.
//
// Optional feature: define ACC_CHECKSUM_EN to add the CHECKSUM output, which
// is the running sum (mod 2^32) of every word read during the current job.
//
// Ports
//   CSI_CLOCK_CLK                 in   clock, all logic on posedge
//   CSI_CLOCK_RESET_N             in   asynchronous active-low reset
//   START                         in   level; a 0->1 transition while idle starts a job
//   SRC_ADDR / DST_ADDR           in   byte addresses, word aligned by the user
//   LENGTH                        in   word count (0 allowed)
//   DONE                          out  one-cycle completion pulse
//   BUSY                          out  high from accepted start through the DONE cycle
//   AVM_AVALONMASTER_ADDRESS      out  byte address of the current request
//   AVM_AVALONMASTER_READ         out  read request
//   AVM_AVALONMASTER_WRITE        out  write request
//   AVM_AVALONMASTER_WAITREQUEST  in   slave stall
//   AVM_AVALONMASTER_READDATA     in   read data, taken when READ & ~WAITREQUEST
//   AVM_AVALONMASTER_WRITEDATA    out  write data
//   CHECKSUM                      out  sum of words read (ACC_CHECKSUM_EN only)
//
// Handshake: a request (READ or WRITE) is held with address and data frozen
// until a cycle in which WAITREQUEST is low; that cycle completes the transfer.
// READ and WRITE are registered and never high together.
// ---------------------------------------------------------------------------
module accelerator_dma_master #(
    parameter int AVM_AVALONMASTER_DATA_WIDTH    = 32,
    parameter int AVM_AVALONMASTER_ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH                   = 16
) (
    input  logic                                      CSI_CLOCK_CLK,
    input  logic                                      CSI_CLOCK_RESET_N,
    input  logic                                      START,
    input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] SRC_ADDR,
    input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] DST_ADDR,
    input  logic [LENGTH_WIDTH-1:0]                   LENGTH,
    output logic                                      DONE,
    output logic                                      BUSY,
    output logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
    output logic                                      AVM_AVALONMASTER_READ,
    output logic                                      AVM_AVALONMASTER_WRITE,
    input  logic                                      AVM_AVALONMASTER_WAITREQUEST,
    input  logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
    output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA
`ifdef ACC_CHECKSUM_EN
    ,
    output logic [31:0]                               CHECKSUM
`endif
);

    localparam int AW = AVM_AVALONMASTER_ADDRESS_WIDTH;
    localparam int DW = AVM_AVALONMASTER_DATA_WIDTH;
    localparam int LW = LENGTH_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    r_state;
    logic          r_start_d;
    logic          r_done;
    logic          r_busy;
    logic          r_read;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_src_ptr;
    logic [AW-1:0] r_dst_ptr;
    logic [LW-1:0] r_remaining;
    logic [DW-1:0] r_wdata;

    logic w_start;
    logic w_accept_start;
    logic w_rd_accept;
    logic w_wr_accept;

    // Edge detect: a held-high START never retriggers; only idle edges count.
    assign w_start        = START & ~r_start_d;
    assign w_accept_start = (r_state == S_IDLE) & w_start;
    assign w_rd_accept    = (r_state == S_RD) & ~AVM_AVALONMASTER_WAITREQUEST;
    assign w_wr_accept    = (r_state == S_WR) & ~AVM_AVALONMASTER_WAITREQUEST;

    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N) begin
        if (!CSI_CLOCK_RESET_N) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
        end else begin
            r_start_d <= START;
            r_done    <= 1'b0;

            // BUSY falls on the same edge that ends the DONE pulse, unless a
            // new job is accepted on that very edge.
            if (w_accept_start) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_src_ptr   <= SRC_ADDR;
                        r_dst_ptr   <= DST_ADDR;
                        r_remaining <= LENGTH;
                        if (LENGTH != '0) begin
                            r_state <= S_RD;
                            r_read  <= 1'b1;
                            r_addr  <= SRC_ADDR;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end

                S_RD: begin
                    if (w_rd_accept) begin
                        r_wdata   <= AVM_AVALONMASTER_READDATA;
                        r_src_ptr <= r_src_ptr + AW'(4);
                        r_read    <= 1'b0;
                        r_write   <= 1'b1;
                        r_addr    <= r_dst_ptr;
                        r_state   <= S_WR;
                    end
                end

                S_WR: begin
                    if (w_wr_accept) begin
                        r_dst_ptr   <= r_dst_ptr + AW'(4);
                        r_remaining <= r_remaining - LW'(1);
                        r_write     <= 1'b0;
                        // Last word: the count is about to reach zero.
                        if (r_remaining == LW'(1)) begin
                            r_state <= S_FIN;
                        end else begin
                            // r_src_ptr already points at the next source word.
                            r_read  <= 1'b1;
                            r_addr  <= r_src_ptr;
                            r_state <= S_RD;
                        end
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACC_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N) begin
        if (!CSI_CLOCK_RESET_N) begin
            r_checksum <= '0;
        end else if (w_accept_start) begin
            r_checksum <= '0;
        end else if (w_rd_accept) begin
            r_checksum <= r_checksum + 32'(AVM_AVALONMASTER_READDATA);
        end
    end

    assign CHECKSUM = r_checksum;
`endif

    assign DONE                       = r_done;
    assign BUSY                       = r_busy;
    assign AVM_AVALONMASTER_ADDRESS   = r_addr;
    assign AVM_AVALONMASTER_READ      = r_read;
    assign AVM_AVALONMASTER_WRITE     = r_write;
    assign AVM_AVALONMASTER_WRITEDATA = r_wdata;

endmodule

// File: tb/tb_accelerator_dma_master.sv
// ---------------------------------------------------------------------------
// tb_accelerator_dma_master
//
// Table-driven bench for accelerator_dma_master. Each table row describes a
// copy job (source, destination, length, slave stall count, data seed) and
// its hand-computed expected latency and checksum. A small Avalon slave model
// with a memory answers the requests; a bus monitor checks that requests stay
// frozen while stalled and that READ/WRITE never overlap. Hand-written
// sequences cover START held high and reset in the middle of a stalled write.
// ---------------------------------------------------------------------------
module tb_accelerator_dma_master;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          stall;
    logic [31:0] base;
    int          exp_lat;
    logic [31:0] exp_sum;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_i;
  logic [31:0] src_i;
  logic [31:0] dst_i;
  logic [15:0] len_i;
  logic        done;
  logic        busy;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic        waitreq;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [31:0] checksum;

  accelerator_dma_master #(
    .AVM_AVALONMASTER_DATA_WIDTH    (32),
    .AVM_AVALONMASTER_ADDRESS_WIDTH (32),
    .LENGTH_WIDTH                   (16)
  ) dut (
    .CSI_CLOCK_CLK                (clk),
    .CSI_CLOCK_RESET_N            (rst_n),
    .START                        (start_i),
    .SRC_ADDR                     (src_i),
    .DST_ADDR                     (dst_i),
    .LENGTH                       (len_i),
    .DONE                         (done),
    .BUSY                         (busy),
    .AVM_AVALONMASTER_ADDRESS     (addr),
    .AVM_AVALONMASTER_READ        (rd),
    .AVM_AVALONMASTER_WRITE       (wr),
    .AVM_AVALONMASTER_WAITREQUEST (waitreq),
    .AVM_AVALONMASTER_READDATA    (rdata),
    .AVM_AVALONMASTER_WRITEDATA   (wdata)
`ifdef ACC_CHECKSUM_EN
    ,
    .CHECKSUM                     (checksum)
`endif
  );

`ifndef ACC_CHECKSUM_EN
  assign checksum = 32'h0;
`endif

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          stall_cycles = 0;
  int          wait_cnt = 0;
  int          wr_count = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  logic [31:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [65:0] prev_bus = '0;
  vec_t        vecs [5];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic [31:0] src, input logic [31:0] dst,
                                  input logic [15:0] len, input int stall,
                                  input logic [31:0] base, input int exp_lat,
                                  input logic [31:0] exp_sum);
    vec_t v;
    v.src = src; v.dst = dst; v.len = len; v.stall = stall;
    v.base = base; v.exp_lat = exp_lat; v.exp_sum = exp_sum;
    return v;
  endfunction

  // Avalon slave model and bus monitor, evaluated on every rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        wait_cnt   = 0;
        prev_stall = 1'b0;
      end else begin
        if (rd || wr) begin
          checks++;
          if (rd && wr) begin
            errors++;
            $display("FAIL rd_wr_overlap: read=%0b write=%0b required not both", rd, wr);
          end
        end
        if (prev_stall) begin
          checks++;
          if ({addr, rd, wr, wdata} !== prev_bus) begin
            errors++;
            $display("FAIL stall_stable: bus 0x%017h required 0x%017h", {addr, rd, wr, wdata}, prev_bus);
          end
        end
        prev_stall = (rd || wr) && waitreq;
        prev_bus   = {addr, rd, wr, wdata};
        if (rd || wr) begin
          if (waitreq) begin
            wait_cnt++;
          end else begin
            wait_cnt = 0;
            if (rd) begin
              rd_log.push_back(addr);
            end else begin
              mem[addr] = wdata;
              wr_count++;
            end
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // slave outputs change on the falling edge, away from the sampling edge
  initial begin
    waitreq = 1'b0;
    rdata   = 32'h0;
    forever begin
      @(negedge clk);
      waitreq = (rd || wr) && (wait_cnt < stall_cycles);
      rdata   = mem.exists(addr) ? mem[addr] : 32'h0;
    end
  end

  // driver: load memory, present inputs, raise START, then scramble inputs
  task automatic launch(input vec_t v);
    logic [31:0] a;
    mem.delete();
    rd_log.delete();
    exp_q.delete();
    wr_count     = 0;
    stall_cycles = v.stall;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 32'(4 * i);
      mem[a] = v.base + 32'(i);
      exp_q.push_back(v.base + 32'(i));
    end
    start_i = 1'b0;
    src_i   = v.src;
    dst_i   = v.dst;
    len_i   = v.len;
    repeat (2) @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    src_i = 32'h0BAD_0000;
    dst_i = 32'h0BAD_1000;
    len_i = 16'h0007;
  endtask

  task automatic finish_job(input vec_t v, input string tag);
    bit          got = 1'b0;
    int          lat = 0;
    logic [31:0] a;
    logic [31:0] act;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done_timeout: no DONE within 400 cycles, required DONE", tag);
    end else begin
      lat = cyc - start_cyc;
      check32({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check32({tag, "_busy_at_done"}, {31'h0, busy}, 32'h1);
      @(posedge clk);
      #1;
      check32({tag, "_done_pulse_end"}, {31'h0, done}, 32'h0);
      check32({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    end
    check32({tag, "_read_count"}, 32'(rd_log.size()), 32'(v.len));
    check32({tag, "_write_count"}, 32'(wr_count), 32'(v.len));
    for (int i = 0; i < rd_log.size() && i < int'(v.len); i++) begin
      check32({tag, "_read_addr"}, rd_log[i], v.src + 32'(4 * i));
    end
    for (int i = 0; i < int'(v.len); i++) begin
      a   = v.dst + 32'(4 * i);
      act = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
      check32({tag, "_dst_data"}, act, exp_q.pop_front());
    end
`ifdef ACC_CHECKSUM_EN
    check32({tag, "_checksum"}, checksum, v.exp_sum);
`endif
  endtask

  initial begin
    vec_t rv;
    int   bad;
    bit   seen;

    vecs[0] = mk_vec(32'h0000_1000, 32'h0000_2000, 16'd4, 0, 32'h1,         10, 32'd10);
    vecs[1] = mk_vec(32'h0000_1000, 32'h0000_2000, 16'd4, 3, 32'h1,         34, 32'd10);
    vecs[2] = mk_vec(32'h0000_1000, 32'h0000_2000, 16'd0, 0, 32'h0,          2, 32'd0);
    vecs[3] = mk_vec(32'hFFFF_FFFC, 32'h0000_3000, 16'd2, 0, 32'hA000_0000,  6, 32'h4000_0001);
    vecs[4] = mk_vec(32'h0000_0100, 32'h0000_0200, 16'd3, 1, 32'h11,        14, 32'h36);

    // reset state
    rst_n   = 1'b0;
    start_i = 1'b0;
    src_i   = 32'h0;
    dst_i   = 32'h0;
    len_i   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_done", {31'h0, done}, 32'h0);
    check32("reset_busy", {31'h0, busy}, 32'h0);
    check32("reset_read", {31'h0, rd}, 32'h0);
    check32("reset_write", {31'h0, wr}, 32'h0);
    check32("reset_addr", addr, 32'h0);
    check32("reset_wdata", wdata, 32'h0);
    check32("reset_checksum", checksum, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // table-driven jobs
    for (int k = 0; k < 5; k++) begin
      launch(vecs[k]);
      finish_job(vecs[k], $sformatf("vec%0d", k));
    end

    // START held high after completion must not start a second job
    launch(vecs[0]);
    finish_job(vecs[0], "hold_first");
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (busy || rd || wr || done) bad++;
    end
    check32("hold_no_retrigger", 32'(bad), 32'h0);
    check32("hold_no_extra_reads", 32'(rd_log.size()), 32'd4);
    launch(vecs[0]);
    finish_job(vecs[0], "hold_second");

    // reset while a write is stalled
    rv = mk_vec(32'h0000_1000, 32'h0000_2000, 16'd4, 50, 32'h1, 0, 32'd0);
    launch(rv);
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (wr) begin
        seen = 1'b1;
        break;
      end
    end
    check32("rst_mid_saw_write", {31'h0, seen}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("rst_mid_read", {31'h0, rd}, 32'h0);
    check32("rst_mid_write", {31'h0, wr}, 32'h0);
    check32("rst_mid_busy", {31'h0, busy}, 32'h0);
    check32("rst_mid_done", {31'h0, done}, 32'h0);
    check32("rst_mid_state", {30'h0, dut.r_state}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(vecs[0]);
    finish_job(vecs[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
